// File: rtl/core_pkg.sv
// Shared core definitions: opcodes, PC sequencer state encoding and ALU flag positions.
package core_pkg;

    // Opcodes live in exe_instr[31:27]
    localparam logic [4:0] OPC_NOP = 5'd0;
    localparam logic [4:0] OPC_J   = 5'd22;
    localparam logic [4:0] OPC_BEQ = 5'd23;
    localparam logic [4:0] OPC_HLT = 5'd24;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        HALT
    } pcseq_state_t;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // A J always redirects; a BEQ redirects only when the last ALU result was zero
    function automatic logic is_branch_taken(input logic [4:0] op, input logic zero);
        return (op == OPC_J) || ((op == OPC_BEQ) && zero);
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter and fetch sequencer for the 3-stage fetch/decode/execute core.
// Resolves J/BEQ/HLT from execute, squashes fetch+decode on a redirect, and
// handles halt/resume.
// Optional build macro PC_SEQUENCER_PERF_EN adds saturating taken-branch and
// flush-cycle counters (taken_cnt, flush_cyc_cnt).
module pc_sequencer
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned OPC_W       = 5,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] exe_instr,
    input  logic [3:0]        flags,
    input  logic              stall,
    input  logic              resume,
    output logic [ADDR_W-1:0] prog_addr,
    output logic              fetch_en,
    output logic              flush,
    output logic              halted,
    output logic              redirect
`ifdef PC_SEQUENCER_PERF_EN
    ,
    output logic [15:0]       taken_cnt,
    output logic [15:0]       flush_cyc_cnt
`endif
);

    localparam int unsigned CNT_W = (FLUSH_DEPTH < 1) ? 1 : $clog2(FLUSH_DEPTH + 1);

    pcseq_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              redirect_q, redirect_d;
    logic              flush_q, flush_d;

    // Execute-stage decode
    logic [OPC_W-1:0]  op;
    logic [ADDR_W-1:0] target;
    logic              br_taken;
    logic              is_hlt;

    assign op       = exe_instr[WORD_W-1 -: OPC_W];
    assign target   = exe_instr[ADDR_W-1:0];
    assign br_taken = is_branch_taken(5'(op), flags[FLAG_Z]);
    assign is_hlt   = (op == OPC_W'(OPC_HLT));

    // Instruction payload bits between opcode and target, plus N/C/V, are not used here
    logic unused_bits;
    assign unused_bits = ^{exe_instr[WORD_W-OPC_W-1:ADDR_W],
                           flags[FLAG_N], flags[FLAG_C], flags[FLAG_V]};

    // State register: FSM state, PC, flush counter and registered pulse outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= ADDR_W'(RESET_PC);
            flush_cnt_q <= '0;
            redirect_q  <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flush_cnt_q <= flush_cnt_d;
            redirect_q  <= redirect_d;
            flush_q     <= flush_d;
        end
    end

    // Next-state: redirect beats stall, stall beats increment; PC wraps naturally
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            RUN: begin
                if (br_taken) begin
                    pc_d        = target;
                    flush_cnt_d = CNT_W'(FLUSH_DEPTH);
                    state_d     = FLUSH;
                end else if (is_hlt) begin
                    state_d = HALT;
                end else if (!stall) begin
                    pc_d = pc_q + 1'b1;
                end
            end
            FLUSH: begin
                // exe_instr is a squashed NOP here, so it is not decoded
                if (!stall) begin
                    pc_d = pc_q + 1'b1;
                end
                if (flush_cnt_q <= CNT_W'(1)) begin
                    flush_cnt_d = '0;
                    state_d     = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            HALT: begin
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Outputs: fetch enable is combinational, redirect/flush are registered pulses
    always_comb begin
        fetch_en   = 1'b0;
        redirect_d = 1'b0;
        flush_d    = 1'b0;
        unique case (state_q)
            RUN: begin
                if (br_taken || is_hlt) begin
                    redirect_d = 1'b1;
                    flush_d    = 1'b1;
                end else begin
                    fetch_en = !stall;
                end
            end
            FLUSH: begin
                fetch_en = !stall;
                // Keep flushing until the last squash cycle has been issued
                flush_d  = (flush_cnt_q > CNT_W'(1));
            end
            HALT: begin
                fetch_en = 1'b0;
            end
            default: begin
                fetch_en = 1'b0;
            end
        endcase
        if (rst) begin
            fetch_en = 1'b0;
        end
    end

    assign prog_addr = pc_q;
    assign redirect  = redirect_q;
    assign flush     = flush_q;
    assign halted    = (state_q == HALT);

`ifdef PC_SEQUENCER_PERF_EN
    logic [15:0] taken_cnt_q, taken_cnt_d;
    logic [15:0] flush_cyc_cnt_q, flush_cyc_cnt_d;

    // Saturating event counters
    always_comb begin
        taken_cnt_d     = taken_cnt_q;
        flush_cyc_cnt_d = flush_cyc_cnt_q;
        if ((state_q == RUN) && br_taken && (taken_cnt_q != 16'hFFFF)) begin
            taken_cnt_d = taken_cnt_q + 16'd1;
        end
        if (flush_q && (flush_cyc_cnt_q != 16'hFFFF)) begin
            flush_cyc_cnt_d = flush_cyc_cnt_q + 16'd1;
        end
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt_q     <= '0;
            flush_cyc_cnt_q <= '0;
        end else begin
            taken_cnt_q     <= taken_cnt_d;
            flush_cyc_cnt_q <= flush_cyc_cnt_d;
        end
    end

    assign taken_cnt     = taken_cnt_q;
    assign flush_cyc_cnt = flush_cyc_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] exe_instr;
    logic [3:0]  flags;
    logic        stall;
    logic        resume;
    logic [8:0]  prog_addr;
    logic        fetch_en;
    logic        flush;
    logic        halted;
    logic        redirect;
`ifdef PC_SEQUENCER_PERF_EN
    logic [15:0] taken_cnt;
    logic [15:0] flush_cyc_cnt;
`endif

    int n_chk;
    int n_fail;

    pc_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .exe_instr (exe_instr),
        .flags     (flags),
        .stall     (stall),
        .resume    (resume),
        .prog_addr (prog_addr),
        .fetch_en  (fetch_en),
        .flush     (flush),
        .halted    (halted),
        .redirect  (redirect)
`ifdef PC_SEQUENCER_PERF_EN
        ,
        .taken_cnt     (taken_cnt),
        .flush_cyc_cnt (flush_cyc_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction word: junk in the middle bits must be ignored
    function automatic logic [31:0] mk(input logic [4:0] op, input logic [8:0] tgt);
        return {op, 18'h2A5A5, tgt};
    endfunction

    localparam logic [4:0] J   = 5'd22;
    localparam logic [4:0] BEQ = 5'd23;
    localparam logic [4:0] HLT = 5'd24;

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        exe_instr = '0;
        flags     = '0;
        stall     = 1'b0;
        resume    = 1'b0;

        // 1: reset then sequential NOP stream
        tick();
        tick();
        check_eq("rst_addr", 32'(prog_addr), 32'h0);
        check_eq("rst_fetch_en", 32'(fetch_en), 32'h0);
        check_eq("rst_flush", 32'(flush), 32'h0);
        check_eq("rst_halted", 32'(halted), 32'h0);
        check_eq("rst_redirect", 32'(redirect), 32'h0);
        rst = 1'b0;
        #1;
        check_eq("t1_fetch_en0", 32'(fetch_en), 32'h1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_eq("t1_addr", 32'(prog_addr), 32'(i));
            check_eq("t1_fetch_en", 32'(fetch_en), 32'h1);
        end

        // 2: J 0x040 at 0x005
        exe_instr = mk(J, 9'h040);
        tick();
        exe_instr = '0;
        check_eq("t2_addr_tgt", 32'(prog_addr), 32'h040);
        check_eq("t2_redirect", 32'(redirect), 32'h1);
        check_eq("t2_flush1", 32'(flush), 32'h1);
        tick();
        check_eq("t2_addr_41", 32'(prog_addr), 32'h041);
        check_eq("t2_flush2", 32'(flush), 32'h1);
        check_eq("t2_redirect_off", 32'(redirect), 32'h0);
        tick();
        check_eq("t2_addr_42", 32'(prog_addr), 32'h042);
        check_eq("t2_flush_off", 32'(flush), 32'h0);

        // 3: BEQ taken with Z=1
        exe_instr = mk(BEQ, 9'h010);
        flags     = 4'b0100;
        tick();
        exe_instr = '0;
        flags     = 4'b0000;
        check_eq("t3_addr_tgt", 32'(prog_addr), 32'h010);
        check_eq("t3_redirect", 32'(redirect), 32'h1);
        check_eq("t3_flush1", 32'(flush), 32'h1);
        tick();
        check_eq("t3_addr_11", 32'(prog_addr), 32'h011);
        check_eq("t3_flush2", 32'(flush), 32'h1);
        tick();
        check_eq("t3_addr_12", 32'(prog_addr), 32'h012);
        check_eq("t3_flush_off", 32'(flush), 32'h0);
`ifdef PC_SEQUENCER_PERF_EN
        check_eq("perf_taken", 32'(taken_cnt), 32'd2);
        check_eq("perf_flush_cyc", 32'(flush_cyc_cnt), 32'd4);
`endif
        // BEQ with Z=0 is a sequential step
        exe_instr = mk(BEQ, 9'h010);
        tick();
        exe_instr = '0;
        check_eq("t3_nt_addr", 32'(prog_addr), 32'h013);
        check_eq("t3_nt_flush", 32'(flush), 32'h0);
        check_eq("t3_nt_redirect", 32'(redirect), 32'h0);
        // Unknown opcode with a target field is also a sequential step
        exe_instr = mk(5'd25, 9'h1AA);
        tick();
        exe_instr = '0;
        check_eq("t3_other_op", 32'(prog_addr), 32'h014);

        // 4: HLT at 0x020
        for (int i = 0; i < 64; i++) begin
            if (prog_addr == 9'h020) break;
            tick();
        end
        check_eq("t4_reach_20", 32'(prog_addr), 32'h020);
        exe_instr = mk(HLT, 9'h155);
        #1;
        check_eq("t4_hlt_fetch_en", 32'(fetch_en), 32'h0);
        tick();
        exe_instr = '0;
        check_eq("t4_halted", 32'(halted), 32'h1);
        check_eq("t4_redirect", 32'(redirect), 32'h1);
        check_eq("t4_flush", 32'(flush), 32'h1);
        check_eq("t4_addr", 32'(prog_addr), 32'h020);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("t4_hold_addr", 32'(prog_addr), 32'h020);
            check_eq("t4_hold_halted", 32'(halted), 32'h1);
            check_eq("t4_hold_fetch_en", 32'(fetch_en), 32'h0);
        end
        check_eq("t4_flush_once", 32'(flush), 32'h0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        #1;
        check_eq("t4_resume_halted", 32'(halted), 32'h0);
        check_eq("t4_resume_addr", 32'(prog_addr), 32'h020);
        check_eq("t4_resume_fetch_en", 32'(fetch_en), 32'h1);
        tick();
        check_eq("t4_resume_step", 32'(prog_addr), 32'h021);
        // resume while running is ignored
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check_eq("t4_resume_run", 32'(prog_addr), 32'h022);
        check_eq("t4_resume_run_halt", 32'(halted), 32'h0);

        // 5: stall at 0x1FE, wrap, J under stall
        exe_instr = mk(J, 9'h1FC);
        tick();
        exe_instr = '0;
        tick();
        tick();
        check_eq("t5_at_1fe", 32'(prog_addr), 32'h1FE);
        stall = 1'b1;
        #1;
        check_eq("t5_stall_fetch_en", 32'(fetch_en), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t5_stall_hold", 32'(prog_addr), 32'h1FE);
        end
        stall = 1'b0;
        tick();
        check_eq("t5_1ff", 32'(prog_addr), 32'h1FF);
        tick();
        check_eq("t5_wrap", 32'(prog_addr), 32'h000);
        stall     = 1'b1;
        exe_instr = mk(J, 9'h0AB);
        tick();
        exe_instr = '0;
        check_eq("t5_j_stall_addr", 32'(prog_addr), 32'h0AB);
        check_eq("t5_j_stall_redirect", 32'(redirect), 32'h1);
        tick();
        check_eq("t5_flush_stall_hold", 32'(prog_addr), 32'h0AB);
        check_eq("t5_flush_stall_flush", 32'(flush), 32'h1);
        stall = 1'b0;

        // 6: reset during FLUSH with one squash cycle left
        rst = 1'b1;
        tick();
        check_eq("t6_addr", 32'(prog_addr), 32'h0);
        check_eq("t6_flush", 32'(flush), 32'h0);
        check_eq("t6_redirect", 32'(redirect), 32'h0);
        check_eq("t6_fetch_en", 32'(fetch_en), 32'h0);
`ifdef PC_SEQUENCER_PERF_EN
        check_eq("t6_perf_taken_clr", 32'(taken_cnt), 32'd0);
        check_eq("t6_perf_flush_clr", 32'(flush_cyc_cnt), 32'd0);
`endif
        rst = 1'b0;
        tick();
        check_eq("t6_run_step", 32'(prog_addr), 32'h1);
        check_eq("t6_run_flush", 32'(flush), 32'h0);
        check_eq("t6_run_halted", 32'(halted), 32'h0);

        // Reset during HALT
        exe_instr = mk(HLT, 9'h000);
        tick();
        exe_instr = '0;
        check_eq("t6_halt_enter", 32'(halted), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_halt_rst_halted", 32'(halted), 32'h0);
        check_eq("t6_halt_rst_addr", 32'(prog_addr), 32'h0);
        tick();
        check_eq("t6_halt_rst_step", 32'(prog_addr), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
